// File: rtl/mem_pkg.sv
// Shared types and constants for the SDRAM write sequencer and its FIFO.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 13;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StGap   = 2'd3
    } wr_state_e;

    // Packed entry: first stream word in [63:32], second in [31:0].
    typedef logic [63:0] entry_t;

endpackage

// File: rtl/sync_fifo_64.sv
// Synchronous FIFO of 64-bit entries; Depth must be a power of two (>= 2).
module sync_fifo_64
    import mem_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  entry_t          data_i,
    input  logic            pop_i,
    output entry_t          data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [PtrW:0]   count_o
);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            push_ok, pop_ok;
    entry_t          mem_q [Depth];

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_write_sequencer.sv
// Packs 32-bit stream words into 64-bit entries and writes them to the SDRAM controller.
// Optional write-completion timeout enabled by defining MEM_WR_TIMEOUT_EN.
module mem_write_sequencer
    import mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic [31:0]       in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [63:0]       mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_w_rn_o,
    output logic              mem_go_o,
    input  logic              mem_valid_i,
    output logic              busy_o,
    output logic              mem_full_o,
    output logic              err_o,
    output logic [ADDR_W:0]   wr_count_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    entry_t            data_q, data_d;
    logic [31:0]       hi_q, hi_d;
    logic              half_q, half_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    entry_t            fifo_wdata, fifo_head;
    logic [CntW-1:0]   unused_fifo_count;
    logic              accept;

`ifdef MEM_WR_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    sync_fifo_64 #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    assign in_ready_o = !rst_i && !full_q && !fifo_full;
    assign accept     = in_valid_i && in_ready_o;
    assign busy_o     = !fifo_empty || half_q || (state_q != StIdle);
    assign mem_w_rn_o = MEM_WRITE;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign mem_full_o = full_q;
    assign err_o      = err_q;
    assign wr_count_o = wr_cnt_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hi_d       = hi_q;
        half_d     = half_q;
        full_d     = full_q;
        err_d      = err_q;
        wr_cnt_d   = wr_cnt_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_wdata = '0;
        mem_go_o   = 1'b0;
`ifdef MEM_WR_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif

        if (accept) begin
            if (half_q) begin
                fifo_push  = 1'b1;
                fifo_wdata = {hi_q, in_data_i};
                half_d     = 1'b0;
            end else if (in_last_i) begin
                fifo_push  = 1'b1;
                fifo_wdata = {in_data_i, 32'h0};
            end else begin
                hi_d   = in_data_i;
                half_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    full_d   = 1'b0;
                    err_d    = 1'b0;
                    wr_cnt_d = '0;
                end
                // full_d so a start that clears mem_full can issue immediately
                if (!fifo_empty && !full_d) begin
                    data_d  = fifo_head;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_go_o = 1'b1;
                state_d  = StWait;
`ifdef MEM_WR_TIMEOUT_EN
                to_cnt_d = ToW'(1);
`endif
            end
            StWait: begin
                if (mem_valid_i) begin
                    fifo_pop = 1'b1;
                    wr_cnt_d = wr_cnt_q + (ADDR_W + 1)'(1);
                    state_d  = StGap;
                    if (addr_q == last_addr_i) begin
                        full_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
`ifdef MEM_WR_TIMEOUT_EN
                // Entry stays at the FIFO head and is re-issued at the same address.
                else if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StGap;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
`endif
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_i && (state_q != StIdle)) begin
            err_d = 1'b1;
        end
        if (mem_valid_i && (state_q != StWait)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            hi_q     <= '0;
            half_q   <= 1'b0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
`ifdef MEM_WR_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            hi_q     <= hi_d;
            half_q   <= half_d;
            full_q   <= full_d;
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
`ifdef MEM_WR_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_write_sequencer.sv
// Scoreboard bench for mem_write_sequencer with a behavioural controller model.
module tb_mem_write_sequencer;

    localparam int unsigned AW = 13;
`ifdef MEM_WR_TIMEOUT_EN
    localparam int unsigned TbTimeout = 8;
    localparam int LatSlow = 6;
`else
    localparam int unsigned TbTimeout = 64;
    localparam int LatSlow = 20;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] last_addr = 13'h1FFF;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [63:0]   mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_w_rn;
    logic          mem_go;
    logic          mem_valid;
    logic          busy;
    logic          mem_full;
    logic          err;
    logic [AW:0]   wr_count;
    logic          mv_auto = 1'b0;
    logic          mv_man = 1'b0;

    assign mem_valid = mv_auto | mv_man;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            ctrl_en = 1'b0;
    int            ctrl_lat = 1;
    logic [63:0]   exp_data[$];
    logic [AW-1:0] exp_addr[$];
    int            go_times[$];
    bit            half_m = 1'b0;
    logic [31:0]   hi_m = '0;
    bit            saw_stall = 1'b0;
    logic [63:0]   mon_d;
    logic [AW-1:0] mon_a;

    mem_write_sequencer #(
        .FIFO_DEPTH  (4),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TbTimeout)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .last_addr_i (last_addr),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_last_i   (in_last),
        .in_ready_o  (in_ready),
        .mem_data_o  (mem_data),
        .mem_addr_o  (mem_addr),
        .mem_w_rn_o  (mem_w_rn),
        .mem_go_o    (mem_go),
        .mem_valid_i (mem_valid),
        .busy_o      (busy),
        .mem_full_o  (mem_full),
        .err_o       (err),
        .wr_count_o  (wr_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Request monitor: pops the scoreboard on every mem_go.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (mem_go) begin
            go_times.push_back(cyc);
            checks++;
            if (exp_data.size() == 0 || exp_addr.size() == 0) begin
                errors++;
                $display("FAIL go_unexpected: addr=%h data=%h, required no request",
                         mem_addr, mem_data);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                if (mem_addr !== mon_a || mem_data !== mon_d || mem_w_rn !== 1'b1) begin
                    errors++;
                    $display("FAIL write_req: addr=%h data=%h w_rn=%b, required addr=%h data=%h w_rn=1",
                             mem_addr, mem_data, mem_w_rn, mon_a, mon_d);
                end
            end
        end
    end

    // Controller model: one completion pulse ctrl_lat cycles into WAIT.
    initial forever begin
        @(posedge clk);
        #1;
        if (ctrl_en && mem_go) begin
            repeat (ctrl_lat) @(posedge clk);
            #1 mv_auto = 1'b1;
            @(posedge clk);
            #1 mv_auto = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w, input logic l);
        int n;
        n = 0;
        in_data  = w;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            saw_stall = 1'b1;
            tick(1);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 500 cycles", in_ready);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (half_m) begin
            exp_data.push_back({hi_m, w});
            half_m = 1'b0;
        end else if (l) begin
            exp_data.push_back({w, 32'h0});
        end else begin
            hi_m   = w;
            half_m = 1'b1;
        end
    endtask

    task automatic start_pulse(input logic [AW-1:0] b, input logic [AW-1:0] l);
        base_addr = b;
        last_addr = l;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b, required 0 within 1000 cycles", name, busy);
        end
    endtask

    task automatic wait_gos(input int target, input string name);
        int n;
        n = 0;
        while (go_times.size() < target && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_go_timeout: requests=%0d, required %0d", name, go_times.size(), target);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({in_ready, mem_go, mem_w_rn, busy, mem_full, err} !== 6'b001000) begin
            errors++;
            $display("FAIL %s_flags: rdy/go/wrn/busy/full/err=%b, required 001000", name,
                     {in_ready, mem_go, mem_w_rn, busy, mem_full, err});
        end
        checks++;
        if (mem_data !== 64'h0 || mem_addr !== '0 || wr_count !== '0) begin
            errors++;
            $display("FAIL %s_values: data=%h addr=%h count=%0d, required 0/0/0", name,
                     mem_data, mem_addr, wr_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_basic_pair();
        ctrl_lat = 1;
        ctrl_en  = 1'b1;
        exp_addr.push_back(13'h010);
        start_pulse(13'h010, 13'h1FFF);
        send(32'hAAAA0001, 1'b0);
        send(32'hBBBB0002, 1'b0);
        wait_idle("basic");
        checks++;
        if (wr_count !== 14'd1 || mem_addr !== 13'h011 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: count=%0d addr=%h err=%b, required 1/011/0",
                     wr_count, mem_addr, err);
        end
        checks++;
        if (go_times.size() != 1) begin
            errors++;
            $display("FAIL basic_go_count: requests=%0d, required 1", go_times.size());
        end
    endtask

    task automatic test_odd_flush();
        exp_addr.push_back(13'h011);
        send(32'h12345678, 1'b1);
        wait_idle("flush");
        checks++;
        if (wr_count !== 14'd2 || mem_addr !== 13'h012 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL flush_after: count=%0d addr=%h pending=%0d, required 2/012/0",
                     wr_count, mem_addr, exp_data.size());
        end
    endtask

    task automatic test_backpressure();
        ctrl_lat  = LatSlow;
        start_pulse(13'h100, 13'h1FFF);
        for (int i = 0; i < 5; i++) exp_addr.push_back(13'h100 + 13'(i));
        saw_stall = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h5000_0000 + 32'(i), 1'b0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b busy=%b, required 0/1", in_ready, busy);
        end
        for (int i = 8; i < 10; i++) send(32'h5000_0000 + 32'(i), 1'b0);
        wait_idle("bp");
        checks++;
        if (wr_count !== 14'd5 || !saw_stall || exp_data.size() != 0 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL bp_after: count=%0d stall=%b pending=%0d/%0d, required 5/1/0/0",
                     wr_count, saw_stall, exp_data.size(), exp_addr.size());
        end
    endtask

    task automatic test_limit();
        int n;
        ctrl_lat = 2;
        exp_addr.push_back(13'h1FFE);
        exp_addr.push_back(13'h1FFF);
        start_pulse(13'h1FFE, 13'h1FFF);
        for (int i = 0; i < 6; i++) send(32'h6000_0000 + 32'(i), 1'b0);
        n = 0;
        while (!mem_full && n < 300) begin
            tick(1);
            n++;
        end
        tick(4);
        checks++;
        if (mem_full !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL limit_full: full=%b in_ready=%b busy=%b, required 1/0/1",
                     mem_full, in_ready, busy);
        end
        checks++;
        if (wr_count !== 14'd2 || exp_data.size() != 1) begin
            errors++;
            $display("FAIL limit_held: count=%0d pending=%0d, required 2/1",
                     wr_count, exp_data.size());
        end
        exp_addr.push_back(13'h0000);
        start_pulse(13'h0000, 13'h1FFF);
        checks++;
        if (mem_full !== 1'b0) begin
            errors++;
            $display("FAIL limit_restart: full=%b, required 0", mem_full);
        end
        wait_idle("limit");
        checks++;
        if (wr_count !== 14'd1 || mem_addr !== 13'h0001 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL limit_after: count=%0d addr=%h pending=%0d, required 1/0001/0",
                     wr_count, mem_addr, exp_data.size());
        end
    endtask

    task automatic test_errors();
        int n0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
        mv_man = 1'b1;
        tick(1);
        mv_man = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_spurious: err=%b, required 1", err);
        end
        start_pulse(13'h020, 13'h1FFF);
        checks++;
        if (err !== 1'b0 || mem_addr !== 13'h020) begin
            errors++;
            $display("FAIL err_start_clear: err=%b addr=%h, required 0/020", err, mem_addr);
        end
        ctrl_lat = LatSlow;
        exp_addr.push_back(13'h020);
        n0 = go_times.size();
        send(32'h7000_0001, 1'b0);
        send(32'h7000_0002, 1'b0);
        wait_gos(n0 + 1, "err");
        tick(1);
        start_pulse(13'h050, 13'h1FFF);
        checks++;
        if (err !== 1'b1 || mem_addr !== 13'h020) begin
            errors++;
            $display("FAIL err_start_wait: err=%b addr=%h, required 1/020", err, mem_addr);
        end
        wait_idle("err");
        checks++;
        if (mem_addr !== 13'h021 || wr_count !== 14'd1) begin
            errors++;
            $display("FAIL err_after: addr=%h count=%0d, required 021/1", mem_addr, wr_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n0;
        ctrl_en = 1'b0;
        start_pulse(13'h030, 13'h1FFF);
        exp_addr.push_back(13'h030);
        n0 = go_times.size();
        send(32'h8000_0001, 1'b0);
        send(32'h8000_0002, 1'b0);
        wait_gos(n0 + 1, "rstwait");
        tick(2);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("rstwait");
        rst = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || mem_go !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_after: busy=%b in_ready=%b go=%b, required 0/1/0",
                     busy, in_ready, mem_go);
        end
        ctrl_en = 1'b1;
    endtask

`ifdef MEM_WR_TIMEOUT_EN
    task automatic test_timeout();
        int n0;
        ctrl_en = 1'b0;
        start_pulse(13'h040, 13'h1FFF);
        exp_addr.push_back(13'h040);
        exp_addr.push_back(13'h040);
        n0 = go_times.size();
        send(32'h9000_0001, 1'b0);
        send(32'h9000_0002, 1'b0);
        exp_data.push_back(64'h9000_0001_9000_0002);
        wait_gos(n0 + 1, "timeout_first");
        tick(2);
        ctrl_lat = 1;
        ctrl_en  = 1'b1;
        wait_gos(n0 + 2, "timeout_reissue");
        if (go_times.size() >= n0 + 2) begin
            checks++;
            if (go_times[n0 + 1] - go_times[n0] != 10 || err !== 1'b1) begin
                errors++;
                $display("FAIL timeout_reissue: spacing=%0d err=%b, required 10/1",
                         go_times[n0 + 1] - go_times[n0], err);
            end
        end
        wait_idle("timeout");
        checks++;
        if (wr_count !== 14'd1 || mem_addr !== 13'h041) begin
            errors++;
            $display("FAIL timeout_after: count=%0d addr=%h, required 1/041", wr_count, mem_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pair();
        test_odd_flush();
        test_backpressure();
        test_limit();
        test_errors();
        test_reset_mid_wait();
`ifdef MEM_WR_TIMEOUT_EN
        test_timeout();
`endif
        tick(5);
        checks++;
        if (exp_data.size() != 0 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d/%0d, required 0/0",
                     exp_data.size(), exp_addr.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_sequencer.md
Name: mem_write_sequencer

Overview:
- Upstream feeder for the SDRAM memory controller. Accepts the 32-bit compressed/encrypted output stream and packs word pairs into 64-bit entries, first word in [63:32].
- Buffers packed entries in a small FIFO.
- Issues one single-cycle go / w_rn=1 write request per entry at an auto-incrementing 13-bit address, and waits for the controller's valid completion pulse before the next request.

Parameters:
- FIFO_DEPTH, 4, number of 64-bit entries buffered; power of two, minimum 2.
- ADDR_W, 13, memory address width; matches the controller address port.
- TIMEOUT_CYC, 64, cycles to wait for mem_valid before flagging an error (used only with the optional feature).

Ports:
- clk  in  1  system clock; also clocks the memory controller.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: loads base_addr into the address pointer and clears mem_full and err.
- base_addr  in  ADDR_W  first write address.
- last_addr  in  ADDR_W  final writable address (inclusive).
- in_data  in  32  stream word.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks final word of a packet; flushes a half-packed entry.
- in_ready  out  1  stream accept; a word transfers when in_valid && in_ready.
- mem_data  out  64  to controller dataToWrite; head FIFO entry, held stable from go until completion.
- mem_addr  out  ADDR_W  to controller address.
- mem_w_rn  out  1  constant 1 (write).
- mem_go  out  1  one-cycle write request.
- mem_valid  in  1  controller completion pulse.
- busy  out  1  high while FIFO non-empty, half word pending, or a request outstanding.
- mem_full  out  1  sticky; set after writing last_addr.
- err  out  1  sticky error flag.
- wr_count  out  ADDR_W+1  entries written since start.

Behaviour:
- Reset values: in_ready 0, mem_go 0, mem_w_rn 1, busy 0, mem_full 0, err 0, wr_count 0, mem_data 0, mem_addr 0. FIFO and packer are emptied, and the FSM goes to IDLE.
- A reset asserted mid-transaction drops the outstanding request silently; the controller must be reset together with this block.
- Packer:
  - The first accepted word is stored as the high half and half_valid is set.
  - The second accepted word completes the entry {hi, lo} and pushes it into the FIFO in the same cycle; half_valid clears.
  - in_last on a first word pushes {word, 32'h0} immediately.
  - in_last on a second word behaves as a normal completion.
- in_ready = !rst && !mem_full && FIFO not full. It is combinational from registered state.
- FIFO: a push and a pop in the same cycle leave the count unchanged. Pushes never occur while full, because in_ready gates them.
- FSM states:
  - IDLE: if FIFO non-empty and !mem_full, go to ISSUE.
  - ISSUE: mem_go=1 for exactly one cycle; mem_addr=addr_ptr, mem_data=FIFO head; go to WAIT.
  - WAIT: hold mem_addr and mem_data. On mem_valid: pop FIFO, increment wr_count, go to GAP. If addr_ptr==last_addr, set mem_full; otherwise addr_ptr+1, wrapping modulo 2^ADDR_W.
  - GAP: one idle cycle so the controller is back in its IDLE state, then go to IDLE.
- Throughput: at most one entry per request cycle, ISSUE + controller latency + GAP. Minimum spacing between mem_go pulses is 11 cycles with the current controller.
- mem_valid seen outside WAIT is ignored and sets err.
- start in any state other than IDLE is ignored and sets err. start in IDLE with an empty FIFO reloads the pointer.
- start and the completing mem_valid in the same cycle: the completion is processed and start sets err.
- mem_full: in_ready=0 and no further requests are issued. Entries remaining in the FIFO are retained until the next start, then written from base_addr.

Optional Feature:
- Macro: MEM_WR_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If mem_valid is absent for TIMEOUT_CYC cycles:
  - err is set and the FSM goes to GAP, then IDLE;
  - the entry is NOT popped and is re-issued at the same address.
- Not defined: WAIT waits indefinitely, no counter is synthesised, and the TIMEOUT_CYC parameter has no effect.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W default;
  - FSM state encoding (IDLE, ISSUE, WAIT, GAP) as a 2-bit typedef;
  - MEM_WRITE/MEM_READ w_rn constants;
  - the packed-entry 64-bit typedef.
- One natural sub-module: sync_fifo_64 (parameterised depth; push/pop/full/empty/count; synchronous active-high reset).

Test Plan:
- Basic pair write: start with base_addr=0x010, then words 0xAAAA0001, 0xBBBB0002. Expected: one mem_go with mem_addr=0x010 and mem_data=0xAAAA0001BBBB0002. After mem_valid, wr_count=1 and the next address is 0x011.
- Odd flush: word 0x12345678 with in_last=1. Expected: entry 0x1234567800000000 written.
- Backpressure: controller model delays mem_valid 20 cycles, stream sends 10 words back-to-back. Expected: in_ready drops after 4 buffered entries, no words are lost, and 5 writes occur in order.
- Limit: base_addr=0x1FFE, last_addr=0x1FFF, 3 entries. Expected: writes to 0x1FFE and 0x1FFF, mem_full=1, the third entry is held, and in_ready=0. After start with base_addr=0x0000, the third entry goes to address 0x0000.
- Errors: spurious mem_valid in IDLE sets err=1. start during WAIT sets err=1 and the pointer is unchanged.
- Reset mid-WAIT: rst for 1 cycle. Expected: all outputs at their reset values the next cycle and the FIFO empty. With MEM_WR_TIMEOUT_EN and TIMEOUT_CYC=8 and no mem_valid: err=1 and a re-issue at the same address 10 cycles after the first mem_go.
